seven_seg_scan: RTL and testbench

Time-multiplexed driver for the Basys 3 four-digit common-anode 7-segment display, sitting directly downstream of the input-select mux that produces the four 4-bit digit values A (leftmost) through D (rightmost). It snapshots the digits once per frame, scans them at a fixed refresh rate with a guard-blank interval between digits to suppress ghosting, and decodes each nibble to active-low segment patterns. Optional leading-zero blanking and per-digit decimal points are supported.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/hex_to_seg.sv | 32 +++
 rtl/seven_seg_scan.sv | 121 ++++++++++++
 tb/tb_seven_seg_scan.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and sizing helpers for the 7-segment scanner
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
  localparam seg_t SEG_HEX_0 = 7'h40;
  localparam seg_t SEG_HEX_1 = 7'h79;
  localparam seg_t SEG_HEX_2 = 7'h24;
  localparam seg_t SEG_HEX_3 = 7'h30;
  localparam seg_t SEG_HEX_4 = 7'h19;
  localparam seg_t SEG_HEX_5 = 7'h12;
  localparam seg_t SEG_HEX_6 = 7'h02;
  localparam seg_t SEG_HEX_7 = 7'h78;
  localparam seg_t SEG_HEX_8 = 7'h00;
  localparam seg_t SEG_HEX_9 = 7'h10;
  localparam seg_t SEG_HEX_A = 7'h08;
  localparam seg_t SEG_HEX_B = 7'h03;
  localparam seg_t SEG_HEX_C = 7'h46;
  localparam seg_t SEG_HEX_D = 7'h21;
  localparam seg_t SEG_HEX_E = 7'h06;
  localparam seg_t SEG_HEX_F = 7'h0E;

  function automatic int calc_period(input int clk_hz, input int digit_hz);
    return clk_hz / digit_hz;
  endfunction

  function automatic int cnt_width(input int period);
    return (period > 2) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational nibble to active-low 7-segment decoder
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit common-anode scanner with guard blanking,
// per-frame snapshot, leading-zero blanking and decimal points
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DIGIT_HZ     = 1_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] dp,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int            PERIOD     = calc_period(CLK_HZ, DIGIT_HZ);
  localparam int            CW         = cnt_width(PERIOD);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  generate
    if (BLANK_CYCLES >= PERIOD || BLANK_CYCLES < 1) begin : g_bad_params
      $error("seven_seg_scan: BLANK_CYCLES must lie in 1..PERIOD-1");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [0:0]    state;
  logic [3:0]    sh_dig [4];
  logic [3:0]    sh_dp;
  logic          sh_lz;
  logic          snap;
  logic [3:0]    sel_dig;
  logic [6:0]    dec_seg;
  logic [3:0]    lz_mask;

  // Frame starts at slot 0 / count 0, which is also the first cycle after reset
  assign snap = (cnt == '0) && (idx == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= 2'd0;
      state <= ST_BLANK;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      case (state)
        ST_BLANK: if (cnt == BLANK_LAST) state <= ST_ON;
        default:  if (cnt == CNT_LAST)   state <= ST_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_dig <= '{default: 4'h0};
      sh_dp  <= 4'h0;
      sh_lz  <= 1'b0;
    end else if (snap) begin
      sh_dig[3] <= A;
      sh_dig[2] <= B;
      sh_dig[1] <= C;
      sh_dig[0] <= D;
      sh_dp     <= dp;
      sh_lz     <= blank_lz;
    end
  end

  // Zero-run from the leftmost digit; the rightmost digit is always shown
  always_comb begin
    lz_mask    = 4'h0;
    lz_mask[3] = sh_lz && (sh_dig[3] == 4'h0);
    lz_mask[2] = lz_mask[3] && (sh_dig[2] == 4'h0);
    lz_mask[1] = lz_mask[2] && (sh_dig[1] == 4'h0);
  end

  assign sel_dig = sh_dig[idx];

  hex_to_seg u_dec (
    .hex (sel_dig),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= snap;
      if (state == ST_ON) begin
        an   <= ~(4'b0001 << idx);
        seg  <= lz_mask[idx] ? SEG_BLANK : dec_seg;
        dp_n <= ~sh_dp[idx];
      end else begin
        an   <= AN_OFF;
        seg  <= SEG_BLANK;
        dp_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan
module tb_seven_seg_scan;

  localparam int PERIOD = 10;
  localparam int BLANK  = 2;
  localparam int FRAME  = 4 * PERIOD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] A = 4'h0, B = 4'h0, C = 4'h0, D = 4'h0;
  logic [3:0] dp = 4'h0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic       dp_n;
  logic [3:0] an;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int         n = 0;
  logic [3:0] m_dig [4];
  logic [3:0] m_dp = 4'h0;
  logic       m_lz = 1'b0;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_scan #(
    .CLK_HZ       (40),
    .DIGIT_HZ     (4),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  // n counts clock edges since reset release; a frame begins on every edge with (n-1) % FRAME == 0
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0;
    end else begin
      n = n + 1;
      if ((n - 1) % FRAME == 0) begin
        m_dig[3] = A;
        m_dig[2] = B;
        m_dig[1] = C;
        m_dig[0] = D;
        m_dp     = dp;
        m_lz     = blank_lz;
      end
    end
  end

  task automatic model_out(output logic [3:0] e_an, output logic [6:0] e_seg,
                           output logic e_dp, output logic e_tick);
    int p;
    int slot;
    int lead;
    e_an = 4'hF;
    e_seg = 7'h7F;
    e_dp = 1'b1;
    e_tick = 1'b0;
    if (reset || n == 0) return;
    e_tick = ((n - 1) % FRAME == 0);
    p    = (n - 1) % PERIOD;
    slot = ((n - 1) / PERIOD) % 4;
    if (p < BLANK) return;
    e_an[slot] = 1'b0;
    e_dp = ~m_dp[slot];
    lead = 0;
    for (int k = 3; k >= 1 && m_dig[k] == 4'h0; k--) lead++;
    if (!(m_lz && slot > 3 - lead)) e_seg = seg_tab[m_dig[slot]];
  endtask

  always @(negedge clk) begin : cmp
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_tick;
    if (chk_en) begin
      model_out(e_an, e_seg, e_dp, e_tick);
      check("model_an", 32'(an), 32'(e_an));
      check("model_seg", 32'(seg), 32'(e_seg));
      check("model_dp_n", 32'(dp_n), 32'(e_dp));
      check("model_tick", 32'(frame_tick), 32'(e_tick));
    end
  end

  task automatic wait_n(input int target);
    int k;
    k = 0;
    while (n != target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (n != target) begin
      errors++;
      $display("FAIL wait_n: reached n=%0d required %0d", n, target);
    end
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    A = a;
    B = b;
    C = c;
    D = d;
  endtask

  task automatic lit(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_dp);
    check({name, "_an"}, 32'(an), 32'(e_an));
    check({name, "_seg"}, 32'(seg), 32'(e_seg));
    check({name, "_dp_n"}, 32'(dp_n), 32'(e_dp));
  endtask

  initial begin
    m_dig = '{default: 4'h0};
    set_digits(4'h6, 4'h4, 4'h9, 4'h6);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    lit("reset_hold", 4'hF, 7'h7F, 1'b1);
    check("reset_tick", 32'(frame_tick), 32'd0);
    reset = 1'b0;

    wait_n(1);
    check("first_tick", 32'(frame_tick), 32'd1);
    wait_n(2);
    check("tick_one_cycle", 32'(frame_tick), 32'd0);
    lit("slot0_blank", 4'hF, 7'h7F, 1'b1);
    wait_n(5);
    lit("f0_slot0", 4'hE, 7'h02, 1'b1);
    wait_n(15);
    lit("f0_slot1", 4'hD, 7'h10, 1'b1);
    wait_n(20);
    set_digits(4'h1, 4'h2, 4'h3, 4'h4);
    wait_n(25);
    lit("f0_slot2_no_tear", 4'hB, 7'h19, 1'b1);
    wait_n(35);
    lit("f0_slot3", 4'h7, 7'h02, 1'b1);
    wait_n(41);
    check("second_tick", 32'(frame_tick), 32'd1);
    wait_n(45);
    lit("f1_slot0", 4'hE, 7'h19, 1'b1);

    wait_n(60);
    blank_lz = 1'b1;
    set_digits(4'h0, 4'h0, 4'h0, 4'h5);
    wait_n(75);
    lit("f1_slot3", 4'h7, 7'h79, 1'b1);
    wait_n(85);
    lit("lz_d", 4'hE, 7'h12, 1'b1);
    wait_n(95);
    lit("lz_c", 4'hD, 7'h7F, 1'b1);
    wait_n(100);
    set_digits(4'h0, 4'h0, 4'h0, 4'h0);
    wait_n(105);
    lit("lz_b", 4'hB, 7'h7F, 1'b1);
    wait_n(115);
    lit("lz_a", 4'h7, 7'h7F, 1'b1);
    wait_n(125);
    lit("lz_all0_d", 4'hE, 7'h40, 1'b1);
    wait_n(135);
    lit("lz_all0_c", 4'hD, 7'h7F, 1'b1);

    wait_n(140);
    dp = 4'b0100;
    blank_lz = 1'b0;
    set_digits(4'hF, 4'hF, 4'hF, 4'hF);
    wait_n(165);
    lit("dp_slot0", 4'hE, 7'h0E, 1'b1);
    wait_n(182);
    lit("dp_blank", 4'hF, 7'h7F, 1'b1);
    wait_n(185);
    lit("dp_slot2", 4'hB, 7'h0E, 1'b0);
    wait_n(195);
    lit("dp_slot3", 4'h7, 7'h0E, 1'b1);

    // Outputs after edge 225 show count 4 of slot 2; the counter itself now sits at 5
    wait_n(225);
    #2 reset = 1'b1;
    #1;
    lit("async_reset", 4'hF, 7'h7F, 1'b1);
    check("async_reset_tick", 32'(frame_tick), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_n(1);
    check("restart_tick", 32'(frame_tick), 32'd1);
    wait_n(5);
    lit("restart_slot0", 4'hE, 7'h0E, 1'b1);
    wait_n(25);
    lit("restart_slot2", 4'hB, 7'h0E, 1'b0);
    wait_n(45);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
